// File: rtl/pp_nested_if.sv
// CPU-side bus of the nested-priority interrupt controller: request lines, software/mask
// access, the irq/ack handshake and the status registers read back by the CPU.
interface pp_nested_if #(
    parameter int NIRQ = 32,
    parameter int VW   = $clog2(NIRQ)
);
    logic            clr;
    logic [NIRQ-1:0] irq_async;
    logic [NIRQ-1:0] sw_w;
    logic            sw_set;
    logic            sw_clr;
    logic            mask_we;
    logic            ack;
    logic            eoi;
    logic            irq;
    logic [VW-1:0]   vec;
    logic [NIRQ-1:0] rz;
    logic [NIRQ-1:0] rs;
    logic [NIRQ-1:0] rp;
    logic [VW:0]     depth;

    modport master (
        output clr, irq_async, sw_w, sw_set, sw_clr, mask_we, ack, eoi,
        input  irq, vec, rz, rs, rp, depth
    );

    modport slave (
        input  clr, irq_async, sw_w, sw_set, sw_clr, mask_we, ack, eoi,
        output irq, vec, rz, rs, rp, depth
    );
endinterface

// File: rtl/pp_nested.sv
// Nested-priority interrupt controller: pending/mask/in-service registers, fixed priority
// (index 0 = NMI) and a four-phase irq/ack handshake. Define PP_AUTOMASK_EN to mask lower levels on grant.
module pp_nested #(
    parameter int NIRQ = 32,
    parameter int VW   = $clog2(NIRQ)
) (
    input logic         __clk,
    input logic         clm_,
    pp_nested_if.slave  bus
);
    localparam logic [1:0]      S_IDLE    = 2'd0;
    localparam logic [1:0]      S_REQ     = 2'd1;
    localparam logic [1:0]      S_HOLD    = 2'd2;
    localparam logic [NIRQ-1:0] ONE       = {{(NIRQ-1){1'b0}}, 1'b1};
    localparam logic [VW:0]     DEPTH_ONE = {{VW{1'b0}}, 1'b1};
    localparam logic [VW:0]     DEPTH_MAX = (VW+1)'(NIRQ);

    logic [NIRQ-1:0] r_sync1, r_sync2, r_edgePrev;
    logic [NIRQ-1:0] r_pend, r_mask, r_inSvc;
    logic [1:0]      r_state;
    logic            r_irq;
    logic [VW-1:0]   r_vec;
    logic [VW:0]     r_depth;

    logic [NIRQ-1:0] w_edge, w_lowSvc, w_below, w_eligible;
    logic [NIRQ-1:0] w_grantOh, w_eoiOh, w_set, w_clear, w_maskNext;
    logic [VW-1:0]   w_lowIdx;
    logic            w_anyElig, w_grant, w_eoiHit;

    // Isolating the lowest in-service bit gives both the eoi target and the nesting ceiling.
    assign w_edge     = r_sync2 & ~r_edgePrev;
    assign w_lowSvc   = r_inSvc & (~r_inSvc + ONE);
    assign w_below    = w_lowSvc - ONE;
    assign w_eligible = r_pend & (r_mask | ONE) & w_below;
    assign w_anyElig  = |w_eligible;

    assign w_grant   = (r_state == S_REQ) && w_anyElig && bus.ack;
    assign w_grantOh = w_grant ? (ONE << r_vec) : '0;
    assign w_eoiOh   = bus.eoi ? w_lowSvc : '0;
    assign w_eoiHit  = bus.eoi && (r_inSvc != '0);

    assign w_set   = w_edge | (bus.sw_set ? bus.sw_w : '0);
    assign w_clear = w_grantOh | (bus.sw_clr ? bus.sw_w : '0);

`ifdef PP_AUTOMASK_EN
    // Grant of v keeps only bits below v; this clear beats a coincident mask write.
    assign w_maskNext = ((bus.mask_we ? bus.sw_w : r_mask) & (w_grant ? (w_grantOh - ONE) : '1)) | ONE;
`else
    assign w_maskNext = (bus.mask_we ? bus.sw_w : r_mask) | ONE;
`endif

    always_comb begin
        w_lowIdx = '0;
        for (int j = NIRQ - 1; j >= 0; j--) begin
            if (w_eligible[j]) w_lowIdx = VW'(j);
        end
    end

    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_edgePrev <= '0;
        end else begin
            r_sync1    <= bus.irq_async;
            r_sync2    <= r_sync1;
            r_edgePrev <= r_sync2;
        end
    end

    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            r_pend  <= '0;
            r_mask  <= ONE;
            r_inSvc <= '0;
            r_depth <= '0;
        end else if (bus.clr) begin
            r_pend  <= '0;
            r_mask  <= ONE;
            r_inSvc <= '0;
            r_depth <= '0;
        end else begin
            r_pend  <= (r_pend & ~w_clear) | w_set;
            r_mask  <= w_maskNext;
            r_inSvc <= (r_inSvc & ~w_eoiOh) | w_grantOh;
            if (w_grant && !w_eoiHit && r_depth != DEPTH_MAX)
                r_depth <= r_depth + DEPTH_ONE;
            else if (w_eoiHit && !w_grant && r_depth != '0)
                r_depth <= r_depth - DEPTH_ONE;
        end
    end

    // Handshake FSM; vec tracks the best candidate while requesting and freezes once acknowledged.
    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_vec   <= '0;
        end else if (bus.clr) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyElig) begin
                        r_vec   <= w_lowIdx;
                        r_irq   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!w_anyElig) begin
                        r_irq   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.ack) begin
                        r_irq   <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_vec <= w_lowIdx;
                    end
                end
                S_HOLD: begin
                    r_irq <= 1'b0;
                    if (!bus.ack) r_state <= S_IDLE;
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.irq   = r_irq;
    assign bus.vec   = r_vec;
    assign bus.rz    = r_pend;
    assign bus.rs    = r_mask | ONE;
    assign bus.rp    = r_inSvc;
    assign bus.depth = r_depth;
endmodule

// File: tb/tb_pp_nested.sv
// Directed bench for pp_nested (NIRQ=32): handshake, nesting, NMI, sw_clr races, ack+eoi
// overlap, automask (when PP_AUTOMASK_EN is defined) and reset during a handshake.
module tb_pp_nested;
    localparam int NIRQ = 32;
    localparam int VW   = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pp_nested_if #(.NIRQ(NIRQ), .VW(VW)) bus ();

    pp_nested #(.NIRQ(NIRQ), .VW(VW)) dut (
        .__clk (clk),
        .clm_  (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.clr = 1'b0; bus.irq_async = '0; bus.sw_w = '0; bus.sw_set = 1'b0;
        bus.sw_clr = 1'b0; bus.mask_we = 1'b0; bus.ack = 1'b0; bus.eoi = 1'b0;
        applyStimulus(2);
        checkOutput("rst_rz", 64'(bus.rz), 64'h0);
        checkOutput("rst_rs", 64'(bus.rs), 64'h1);
        checkOutput("rst_rp", 64'(bus.rp), 64'h0);
        checkOutput("rst_depth", 64'(bus.depth), 64'h0);
        checkOutput("rst_irq", 64'(bus.irq), 64'h0);
        checkOutput("rst_vec", 64'(bus.vec), 64'h0);
        rst_n = 1'b1;
        applyStimulus(1);

        // Edge request on source 5
        bus.mask_we = 1'b1; bus.sw_w = '1;
        applyStimulus(1);
        bus.mask_we = 1'b0; bus.sw_w = '0;
        checkOutput("mask_all", 64'(bus.rs), 64'hFFFF_FFFF);
        bus.irq_async[5] = 1'b1;
        applyStimulus(1);
        bus.irq_async[5] = 1'b0;
        checkOutput("e5_irq_n", 64'(bus.irq), 64'h0);
        applyStimulus(1);
        checkOutput("e5_rz_n1", 64'(bus.rz), 64'h0);
        applyStimulus(1);
        checkOutput("e5_rz_n2", 64'(bus.rz), 64'h20);
        checkOutput("e5_irq_n2", 64'(bus.irq), 64'h0);
        applyStimulus(1);
        checkOutput("e5_irq_n3", 64'(bus.irq), 64'h1);
        checkOutput("e5_vec", 64'(bus.vec), 64'd5);
        bus.ack = 1'b1;
        applyStimulus(1);
        checkOutput("e5_ack_irq", 64'(bus.irq), 64'h0);
        checkOutput("e5_ack_rp", 64'(bus.rp), 64'h20);
        checkOutput("e5_ack_rz", 64'(bus.rz), 64'h0);
        checkOutput("e5_ack_depth", 64'(bus.depth), 64'd1);
        bus.ack = 1'b0;
        applyStimulus(1);

        // Nesting: 3 preempts under 5, 9 waits until in-service clears
        bus.sw_set = 1'b1; bus.sw_w = 32'h208;
        applyStimulus(1);
        bus.sw_set = 1'b0; bus.sw_w = '0;
        checkOutput("n_rz", 64'(bus.rz), 64'h208);
        applyStimulus(1);
        checkOutput("n_irq3", 64'(bus.irq), 64'h1);
        checkOutput("n_vec3", 64'(bus.vec), 64'd3);
        bus.ack = 1'b1;
        applyStimulus(1);
        checkOutput("n_rp", 64'(bus.rp), 64'h28);
        checkOutput("n_depth2", 64'(bus.depth), 64'd2);
        bus.ack = 1'b0;
        applyStimulus(2);
        checkOutput("n_no9", 64'(bus.irq), 64'h0);
        bus.eoi = 1'b1;
        applyStimulus(1);
        checkOutput("n_eoi1_rp", 64'(bus.rp), 64'h20);
        checkOutput("n_eoi1_depth", 64'(bus.depth), 64'd1);
        applyStimulus(1);
        bus.eoi = 1'b0;
        checkOutput("n_eoi2_rp", 64'(bus.rp), 64'h0);
        checkOutput("n_eoi2_depth", 64'(bus.depth), 64'd0);
        applyStimulus(1);
        checkOutput("n_irq9", 64'(bus.irq), 64'h1);
        checkOutput("n_vec9", 64'(bus.vec), 64'd9);

        // Build depth 2 (9 then 2), then ack of 1 together with eoi
        bus.ack = 1'b1;
        applyStimulus(1);
        bus.ack = 1'b0;
        checkOutput("a9_rp", 64'(bus.rp), 64'h200);
        applyStimulus(1);
        bus.sw_set = 1'b1; bus.sw_w = 32'h4;
        applyStimulus(1);
        bus.sw_set = 1'b0; bus.sw_w = '0;
        applyStimulus(1);
        checkOutput("a2_vec", 64'(bus.vec), 64'd2);
        bus.ack = 1'b1;
        applyStimulus(1);
        bus.ack = 1'b0;
        checkOutput("a2_rp", 64'(bus.rp), 64'h204);
        checkOutput("a2_depth", 64'(bus.depth), 64'd2);
        applyStimulus(1);
        bus.sw_set = 1'b1; bus.sw_w = 32'h2;
        applyStimulus(1);
        bus.sw_set = 1'b0; bus.sw_w = '0;
        applyStimulus(1);
        checkOutput("a1_vec", 64'(bus.vec), 64'd1);
        bus.ack = 1'b1; bus.eoi = 1'b1;
        applyStimulus(1);
        bus.ack = 1'b0; bus.eoi = 1'b0;
        checkOutput("ae_rp", 64'(bus.rp), 64'h202);
        checkOutput("ae_depth", 64'(bus.depth), 64'd2);
        checkOutput("ae_rz", 64'(bus.rz), 64'h0);
        applyStimulus(1);
        bus.clr = 1'b1;
        applyStimulus(1);
        bus.clr = 1'b0;
        checkOutput("clr_rp", 64'(bus.rp), 64'h0);
        checkOutput("clr_depth", 64'(bus.depth), 64'd0);
        checkOutput("clr_rs", 64'(bus.rs), 64'h1);

        // NMI ignores the mask; source 1 stays masked
        bus.mask_we = 1'b1; bus.sw_w = '0;
        applyStimulus(1);
        bus.mask_we = 1'b0;
        checkOutput("nmi_rs", 64'(bus.rs), 64'h1);
        bus.sw_set = 1'b1; bus.sw_w = 32'h3;
        applyStimulus(1);
        bus.sw_set = 1'b0; bus.sw_w = '0;
        applyStimulus(1);
        checkOutput("nmi_irq", 64'(bus.irq), 64'h1);
        checkOutput("nmi_vec", 64'(bus.vec), 64'd0);
        bus.ack = 1'b1;
        applyStimulus(1);
        bus.ack = 1'b0;
        checkOutput("nmi_rz", 64'(bus.rz), 64'h2);
        checkOutput("nmi_rp", 64'(bus.rp), 64'h1);
        applyStimulus(1);
        bus.eoi = 1'b1;
        applyStimulus(1);
        bus.eoi = 1'b0;
        applyStimulus(2);
        checkOutput("nmi_b1_quiet", 64'(bus.irq), 64'h0);
        bus.sw_clr = 1'b1; bus.sw_w = 32'h2;
        applyStimulus(1);
        bus.sw_clr = 1'b0; bus.sw_w = '0;
        checkOutput("nmi_sw_clr", 64'(bus.rz), 64'h0);

        // sw_clr withdraws a request; edge beats a coincident sw_clr
        bus.mask_we = 1'b1; bus.sw_w = '1;
        applyStimulus(1);
        bus.mask_we = 1'b0;
        bus.sw_set = 1'b1; bus.sw_w = 32'h80;
        applyStimulus(1);
        bus.sw_set = 1'b0; bus.sw_w = '0;
        applyStimulus(1);
        checkOutput("c7_vec", 64'(bus.vec), 64'd7);
        bus.sw_clr = 1'b1; bus.sw_w = 32'h80;
        applyStimulus(1);
        bus.sw_clr = 1'b0; bus.sw_w = '0;
        checkOutput("c7_rz", 64'(bus.rz), 64'h0);
        applyStimulus(1);
        checkOutput("c7_irq_drop", 64'(bus.irq), 64'h0);
        bus.irq_async[7] = 1'b1;
        applyStimulus(1);
        bus.irq_async[7] = 1'b0;
        applyStimulus(1);
        bus.sw_clr = 1'b1; bus.sw_w = 32'h80;
        applyStimulus(1);
        bus.sw_clr = 1'b0; bus.sw_w = '0;
        checkOutput("c7_set_wins", 64'(bus.rz), 64'h80);
        applyStimulus(1);
        checkOutput("c7_reirq", 64'(bus.irq), 64'h1);
        bus.clr = 1'b1;
        applyStimulus(1);
        bus.clr = 1'b0;
        checkOutput("c7_clr_irq", 64'(bus.irq), 64'h0);

        // Grant of vector 4: lower levels masked only with automask
        bus.mask_we = 1'b1; bus.sw_w = '1;
        applyStimulus(1);
        bus.mask_we = 1'b0;
        bus.sw_set = 1'b1; bus.sw_w = 32'h10;
        applyStimulus(1);
        bus.sw_set = 1'b0; bus.sw_w = '0;
        applyStimulus(1);
        checkOutput("am_vec", 64'(bus.vec), 64'd4);
        bus.ack = 1'b1;
        applyStimulus(1);
`ifdef PP_AUTOMASK_EN
        checkOutput("am_rs", 64'(bus.rs), 64'hF);
`else
        checkOutput("am_rs", 64'(bus.rs), 64'hFFFF_FFFF);
`endif
        checkOutput("am_rp", 64'(bus.rp), 64'h10);

        // Reset while the CPU still holds ack
        rst_n = 1'b0;
        #1;
        checkOutput("mr_irq", 64'(bus.irq), 64'h0);
        checkOutput("mr_rp", 64'(bus.rp), 64'h0);
        checkOutput("mr_depth", 64'(bus.depth), 64'd0);
        checkOutput("mr_rs", 64'(bus.rs), 64'h1);
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(2);
        checkOutput("mr_idle_irq", 64'(bus.irq), 64'h0);
        bus.ack = 1'b0;
        applyStimulus(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pp_nested.md
# pp_nested

Parametrised nested-priority interrupt controller, the successor of the fixed 32-source interrupt block in the CPU. It latches NIRQ edge or software requests into a pending register and gates them with a per-source mask register. It resolves them through a fixed priority chain with nesting against an in-service register, and presents a vector to the CPU control unit over a four-phase request/acknowledge handshake. End-of-interrupt retires the highest-priority in-service level.

## Interface
Parameters:
- NIRQ, 32: number of request sources, 2..64; index 0 is highest priority and unmaskable (NMI)
- VW, 5: vector width, equal to clog2(NIRQ)

Ports:
- __clk  in  1  system clock; the block has one clock
- clm_  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of pending, in-service, mask and depth (CPU clear)
- irq_async  in  NIRQ  asynchronous level request lines; a rising edge requests
- sw_w  in  NIRQ  software set/clear operand (W bus)
- sw_set  in  1  set pending bits where sw_w=1
- sw_clr  in  1  clear pending bits where sw_w=1
- mask_we  in  1  load mask from sw_w
- ack  in  1  CPU acknowledge; four-phase handshake with irq
- eoi  in  1  end-of-interrupt strobe, one cycle
- irq  out  1  interrupt request to CPU
- vec  out  VW  index of the granted/requesting source
- rz  out  NIRQ  pending register
- rs  out  NIRQ  mask register; bit 0 reads 1
- rp  out  NIRQ  in-service register
- depth  out  VW+1  nesting depth

## Operation
- Synchroniser: 2 flops per irq_async line, then an edge register. A synchronised 0->1 sets pending[j].
- Pending update priority per bit: edge or sw_set sets; else ack-grant of j or sw_clr clears. Set wins over a simultaneous clear.
- Eligible[j] = pending[j] & (rs[j] | j==0) & (j < lowest set index of rp, or rp==0).
- FSM states:
  - IDLE: when eligible is nonzero, load vec with the lowest eligible index and go to REQ; irq=1 registered.
  - REQ: vec re-evaluated every cycle, so a higher-priority arrival preempts. If eligible becomes 0, go to IDLE and drop irq. On ack=1: clear pending[vec], set rp[vec], depth+1, go to HOLD.
  - HOLD: irq=0, vec frozen; wait for ack=0, then go to IDLE.
- eoi: clears the lowest set index of rp and decrements depth. No effect if rp==0.
- eoi and ack in the same cycle: eoi selects its bit from rp before the ack update, both apply, and depth is unchanged.
- mask_we: rs <= sw_w, bit 0 forced to 1. A write coinciding with an automask clear (Configuration) loses to the clear on the affected bits.
- clr acts like reset but synchronously: FSM returns to IDLE and the synchroniser flops are kept.

## Timing
- Reset (clm_ low, asynchronous): rz=0, rs=1 (bit 0 only), rp=0, depth=0, irq=0, vec=0, FSM IDLE, synchronisers 0.
- irq_async rising before edge N: pending set at edge N+2, irq high after edge N+3.
- sw_set at edge N: pending after N, irq after N+1.
- ack sampled high in REQ at edge N: irq low and rp/pending updated after N. The next request can assert no earlier than 1 cycle after ack is sampled low.
- Reset asserted mid-handshake: all state cleared immediately; a CPU still holding ack sees irq=0 and the FSM stays in IDLE.
- depth saturates at NIRQ and never underflows.

## Configuration
- PP_AUTOMASK_EN defined: on an ack grant of vector v, rs bits with index >= v (except bit 0) are cleared in the same cycle. This mirrors the hardware mask-drop of lower levels. Software restores the mask.
- Undefined: rs changes only on mask_we, clr or reset.

## Test plan
- Reset, then mask_we with sw_w=all 1, then pulse irq_async[5] -> irq rises 4 cycles after the edge, vec=5; ack -> rp[5]=1, rz[5]=0, depth=1.
- Source 5 in service, then sw_set on bits 3 and 9 -> irq with vec=3 only; after the ack, eoi x2 -> rp=0, and irq reasserts with vec=9.
- rs=0, sw_set bit 0 and bit 1 -> irq with vec=0 (NMI unmaskable); bit 1 never requests.
- In REQ with vec=7, sw_clr bit 7 -> irq drops next cycle and the FSM returns to IDLE; edge on bit 7 in the same cycle as sw_clr -> pending stays 1.
- ack and eoi in the same cycle with depth=2 -> depth stays 2, rp swaps bits correctly.
- PP_AUTOMASK_EN defined, ack on vec=4 -> rs[4..NIRQ-1]=0 and rs[0..3] unchanged; without the macro, rs is unchanged.
